// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, control codes and types for the decode/control stage
package decode_pkg;

    // Major opcodes recognised by the stage
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // ALU operation codes; 0 means no ALU operation
    localparam logic [5:0] ALU_NONE   = 6'd0;
    localparam logic [5:0] ALU_ADD    = 6'd1;
    localparam logic [5:0] ALU_SUB    = 6'd2;
    localparam logic [5:0] ALU_SLL    = 6'd3;
    localparam logic [5:0] ALU_SLT    = 6'd4;
    localparam logic [5:0] ALU_SLTU   = 6'd5;
    localparam logic [5:0] ALU_XOR    = 6'd6;
    localparam logic [5:0] ALU_SRL    = 6'd7;
    localparam logic [5:0] ALU_SRA    = 6'd8;
    localparam logic [5:0] ALU_OR     = 6'd9;
    localparam logic [5:0] ALU_AND    = 6'd10;
    localparam logic [5:0] ALU_ADDI   = 6'd11;
    localparam logic [5:0] ALU_SLTI   = 6'd12;
    localparam logic [5:0] ALU_SLTIU  = 6'd13;
    localparam logic [5:0] ALU_XORI   = 6'd14;
    localparam logic [5:0] ALU_ORI    = 6'd15;
    localparam logic [5:0] ALU_ANDI   = 6'd16;
    localparam logic [5:0] ALU_SLLI   = 6'd17;
    localparam logic [5:0] ALU_SRLI   = 6'd18;
    localparam logic [5:0] ALU_SRAI   = 6'd19;
    localparam logic [5:0] ALU_LB     = 6'd20;
    localparam logic [5:0] ALU_LH     = 6'd21;
    localparam logic [5:0] ALU_LW     = 6'd22;
    localparam logic [5:0] ALU_LBU    = 6'd23;
    localparam logic [5:0] ALU_LHU    = 6'd24;
    localparam logic [5:0] ALU_SB     = 6'd25;
    localparam logic [5:0] ALU_SH     = 6'd26;
    localparam logic [5:0] ALU_SW     = 6'd27;
    localparam logic [5:0] ALU_BEQ    = 6'd28;
    localparam logic [5:0] ALU_BNE    = 6'd29;
    localparam logic [5:0] ALU_BLT    = 6'd30;
    localparam logic [5:0] ALU_BGE    = 6'd31;
    localparam logic [5:0] ALU_BLTU   = 6'd32;
    localparam logic [5:0] ALU_BGEU   = 6'd33;
    localparam logic [5:0] ALU_JAL    = 6'd34;
    // MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU follow in funct3 order
    localparam logic [5:0] ALU_MUL    = 6'd35;

    // Branch condition codes
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;

    // Memory access sizes
    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    // One decoded entry as held in a buffer slot
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [5:0] alu;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [2:0] branch_type;
        logic       jump;
        logic       lui_control;
        logic       illegal;
    } ctrl_t;

    // Occupancy of the two-slot skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// rtl/decode_ctrl_stage_if.sv - fetch-side and execute-side signals of the decode stage
interface decode_ctrl_stage_if #(
    parameter int XLEN  = 32,
    parameter int ALUW  = 6,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [ALUW-1:0]   alu_control;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [2:0]        branch_type;
    logic              jump;
    logic              lui_control;
    logic              illegal;
    logic [CNT_W-1:0]  dec_count;
    logic [CNT_W-1:0]  ill_count;

    // Stage view
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, alu_control,
               reg_write, mem_to_reg, mem_read, mem_write, mem_size, mem_unsigned,
               branch_type, jump, lui_control, illegal, dec_count, ill_count
    );

    // Fetch/execute view
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, alu_control,
               reg_write, mem_to_reg, mem_read, mem_write, mem_size, mem_unsigned,
               branch_type, jump, lui_control, illegal, dec_count, ill_count
    );
endinterface

// File: rtl/rv_decode_comb.sv
// rtl/rv_decode_comb.sv - combinational RV32I(+M) instruction to control bundle decoder
module rv_decode_comb
    import decode_pkg::*;
#(
    parameter int EN_M = 0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;
    ctrl_t      c;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Decode one instruction word; every field starts at 0 so nothing is left undefined
    always_comb begin
        c           = '0;
        bad         = 1'b0;
        c.rd        = instr_i[11:7];
        c.rs1       = instr_i[19:15];
        c.rs2       = instr_i[24:20];
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'd0:    c.alu = ALU_ADD;
                        3'd1:    c.alu = ALU_SLL;
                        3'd2:    c.alu = ALU_SLT;
                        3'd3:    c.alu = ALU_SLTU;
                        3'd4:    c.alu = ALU_XOR;
                        3'd5:    c.alu = ALU_SRL;
                        3'd6:    c.alu = ALU_OR;
                        default: c.alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd0)      c.alu = ALU_SUB;
                    else if (funct3 == 3'd5) c.alu = ALU_SRA;
                    else                     bad   = 1'b1;
                end else if (funct7 == F7_MULDIV && EN_M != 0) begin
                    c.alu = ALU_MUL + {3'b000, funct3};
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IALU: begin
                c.reg_write = 1'b1;
                case (funct3)
                    3'd0:    c.alu = ALU_ADDI;
                    3'd2:    c.alu = ALU_SLTI;
                    3'd3:    c.alu = ALU_SLTIU;
                    3'd4:    c.alu = ALU_XORI;
                    3'd6:    c.alu = ALU_ORI;
                    3'd7:    c.alu = ALU_ANDI;
                    3'd1: begin
                        if (funct7 == F7_BASE) c.alu = ALU_SLLI;
                        else                   bad   = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     c.alu = ALU_SRLI;
                        else if (funct7 == F7_ALT) c.alu = ALU_SRAI;
                        else                       bad   = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                c.reg_write    = 1'b1;
                c.mem_read     = 1'b1;
                c.mem_to_reg   = 1'b1;
                c.mem_size     = funct3[1:0];
                c.mem_unsigned = funct3[2];
                case (funct3)
                    3'd0:    c.alu = ALU_LB;
                    3'd1:    c.alu = ALU_LH;
                    3'd2:    c.alu = ALU_LW;
                    3'd4:    c.alu = ALU_LBU;
                    3'd5:    c.alu = ALU_LHU;
                    default: bad   = 1'b1;
                endcase
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.mem_size  = funct3[1:0];
                case (funct3)
                    3'd0:    c.alu = ALU_SB;
                    3'd1:    c.alu = ALU_SH;
                    3'd2:    c.alu = ALU_SW;
                    default: bad   = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                case (funct3)
                    3'd0: begin c.alu = ALU_BEQ;  c.branch_type = BR_EQ;  end
                    3'd1: begin c.alu = ALU_BNE;  c.branch_type = BR_NE;  end
                    3'd4: begin c.alu = ALU_BLT;  c.branch_type = BR_LT;  end
                    3'd5: begin c.alu = ALU_BGE;  c.branch_type = BR_GE;  end
                    3'd6: begin c.alu = ALU_BLTU; c.branch_type = BR_LTU; end
                    3'd7: begin c.alu = ALU_BGEU; c.branch_type = BR_GEU; end
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                c.alu       = ALU_JAL;
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
            end
            OP_LUI: begin
                c.reg_write   = 1'b1;
                c.lui_control = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        // Illegal entries carry only their register indices and the illegal flag
        if (bad) begin
            c.alu          = ALU_NONE;
            c.reg_write    = 1'b0;
            c.mem_to_reg   = 1'b0;
            c.mem_read     = 1'b0;
            c.mem_write    = 1'b0;
            c.mem_size     = MEM_SZ_B;
            c.mem_unsigned = 1'b0;
            c.branch_type  = BR_NONE;
            c.jump         = 1'b0;
            c.lui_control  = 1'b0;
            c.illegal      = 1'b1;
        end
    end

    assign ctrl_o = c;

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered decode stage with 2-entry skid buffer and counters
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALUW  = 6,
    parameter int EN_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    decode_ctrl_stage_if.slave   bus
);

    buf_state_e       state_q, state_d;
    ctrl_t            dec;
    ctrl_t            main_q, skid_q;
    logic [XLEN-1:0]  main_pc_q, skid_pc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] dec_count_q, ill_count_q;
    logic             accept, consume;

    rv_decode_comb #(.EN_M(EN_M)) u_decode (
        .instr_i (bus.in_instr),
        .ctrl_o  (dec)
    );

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid_q & bus.out_ready;

    // Buffer occupancy for next cycle; flush always empties
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !consume)      state_d = ST_FULL;
                    else if (!accept && consume) state_d = ST_EMPTY;
                end
                ST_FULL:  if (consume) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Skid buffer: slot loads and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            main_pc_q   <= '0;
            skid_pc_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            if (!flush) begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_q    <= dec;
                            main_pc_q <= bus.in_pc;
                        end
                    end
                    ST_ONE: begin
                        // The presented entry only changes when it is consumed
                        if (accept && consume) begin
                            main_q    <= dec;
                            main_pc_q <= bus.in_pc;
                        end else if (accept) begin
                            skid_q    <= dec;
                            skid_pc_q <= bus.in_pc;
                        end
                    end
                    ST_FULL: begin
                        if (consume) begin
                            main_q    <= skid_q;
                            main_pc_q <= skid_pc_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Saturating counters of consumed legal and illegal entries
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_count_q <= '0;
            ill_count_q <= '0;
        end else if (consume) begin
            if (main_q.illegal) begin
                if (!(&ill_count_q)) ill_count_q <= ill_count_q + 1'b1;
            end else begin
                if (!(&dec_count_q)) dec_count_q <= dec_count_q + 1'b1;
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = main_pc_q;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_rs1      = main_q.rs1;
    assign bus.out_rs2      = main_q.rs2;
    assign bus.alu_control  = ALUW'(main_q.alu);
    assign bus.reg_write    = main_q.reg_write;
    assign bus.mem_to_reg   = main_q.mem_to_reg;
    assign bus.mem_read     = main_q.mem_read;
    assign bus.mem_write    = main_q.mem_write;
    assign bus.mem_size     = main_q.mem_size;
    assign bus.mem_unsigned = main_q.mem_unsigned;
    assign bus.branch_type  = main_q.branch_type;
    assign bus.jump         = main_q.jump;
    assign bus.lui_control  = main_q.lui_control;
    assign bus.illegal      = main_q.illegal;
    assign bus.dec_count    = dec_count_q;
    assign bus.ill_count    = ill_count_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - randomized self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;

    typedef logic [65:0] vec_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         cf3;
        bit         cf7;
        int         kind;
        logic [2:0] br;
        logic [5:0] alu;
    } ref_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    decode_ctrl_stage_if #(.XLEN(32), .ALUW(6), .CNT_W(CW)) bus ();

    decode_ctrl_stage #(.XLEN(32), .ALUW(6), .EN_M(0), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    ref_t tbl[$];
    vec_t sb_q[$];
    int   m_dec = 0;
    int   m_ill = 0;
    logic [31:0] pc_ctr = 32'h1000;

    // Legal instruction table in mnemonic order; ALU code is position + 1
    function automatic void add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input bit cf3, input bit cf7, input int kind, input logic [2:0] br);
        ref_t e;
        e.op = op; e.f3 = f3; e.f7 = f7; e.cf3 = cf3; e.cf7 = cf7; e.kind = kind; e.br = br;
        e.alu = (kind == K_LUI) ? 6'd0 : 6'(tbl.size() + 1);
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        add(7'h33,0,7'h00,1,1,K_R,0); add(7'h33,0,7'h20,1,1,K_R,0); add(7'h33,1,7'h00,1,1,K_R,0);
        add(7'h33,2,7'h00,1,1,K_R,0); add(7'h33,3,7'h00,1,1,K_R,0); add(7'h33,4,7'h00,1,1,K_R,0);
        add(7'h33,5,7'h00,1,1,K_R,0); add(7'h33,5,7'h20,1,1,K_R,0); add(7'h33,6,7'h00,1,1,K_R,0);
        add(7'h33,7,7'h00,1,1,K_R,0);
        add(7'h13,0,0,1,0,K_I,0); add(7'h13,2,0,1,0,K_I,0); add(7'h13,3,0,1,0,K_I,0);
        add(7'h13,4,0,1,0,K_I,0); add(7'h13,6,0,1,0,K_I,0); add(7'h13,7,0,1,0,K_I,0);
        add(7'h13,1,7'h00,1,1,K_I,0); add(7'h13,5,7'h00,1,1,K_I,0); add(7'h13,5,7'h20,1,1,K_I,0);
        add(7'h03,0,0,1,0,K_LD,0); add(7'h03,1,0,1,0,K_LD,0); add(7'h03,2,0,1,0,K_LD,0);
        add(7'h03,4,0,1,0,K_LD,0); add(7'h03,5,0,1,0,K_LD,0);
        add(7'h23,0,0,1,0,K_ST,0); add(7'h23,1,0,1,0,K_ST,0); add(7'h23,2,0,1,0,K_ST,0);
        add(7'h63,0,0,1,0,K_BR,1); add(7'h63,1,0,1,0,K_BR,2); add(7'h63,4,0,1,0,K_BR,3);
        add(7'h63,5,0,1,0,K_BR,4); add(7'h63,6,0,1,0,K_BR,5); add(7'h63,7,0,1,0,K_BR,6);
        add(7'h6F,0,0,0,0,K_JAL,0);
        add(7'h37,0,0,0,0,K_LUI,0);
    endfunction

    // Expected presented entry for an instruction at a given PC
    function automatic vec_t ref_vec(input logic [31:0] w, input logic [31:0] pc);
        logic [5:0] alu; logic rw, m2r, mr, mw, mu, jmp, lui, ill; logic [1:0] sz; logic [2:0] br;
        alu = 0; rw = 0; m2r = 0; mr = 0; mw = 0; mu = 0; jmp = 0; lui = 0; ill = 1; sz = 0; br = 0;
        foreach (tbl[i]) begin
            if (w[6:0] == tbl[i].op && (!tbl[i].cf3 || w[14:12] == tbl[i].f3)
                && (!tbl[i].cf7 || w[31:25] == tbl[i].f7)) begin
                ill = 0; alu = tbl[i].alu;
                case (tbl[i].kind)
                    K_R, K_I: rw = 1;
                    K_LD:  begin rw = 1; mr = 1; m2r = 1; sz = w[13:12]; mu = w[14]; end
                    K_ST:  begin mw = 1; sz = w[13:12]; end
                    K_BR:  br = tbl[i].br;
                    K_JAL: begin rw = 1; jmp = 1; end
                    default: begin rw = 1; lui = 1; end
                endcase
            end
        end
        return {pc, w[11:7], w[19:15], w[24:20], alu, rw, m2r, mr, mw, sz, mu, br, jmp, lui, ill};
    endfunction

    function automatic vec_t observe();
        return {bus.out_pc, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.alu_control, bus.reg_write,
                bus.mem_to_reg, bus.mem_read, bus.mem_write, bus.mem_size, bus.mem_unsigned,
                bus.branch_type, bus.jump, bus.lui_control, bus.illegal};
    endfunction

    function automatic logic [31:0] gen_legal();
        ref_t e; logic [31:0] w;
        e = tbl[$urandom_range(0, tbl.size() - 1)];
        w = $urandom; w[6:0] = e.op;
        if (e.cf3) w[14:12] = e.f3;
        if (e.cf7) w[31:25] = e.f7;
        return w;
    endfunction

    // Drive one cycle from a negedge; keeps the scoreboard and counter model, returns what was consumed
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                        output logic got, output vec_t obs, output vec_t exp);
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc_ctr; bus.out_ready = rdy; flush = fl;
        got = bus.out_valid & rdy;
        obs = observe();
        exp = ~obs;
        if (got && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            if (exp[0]) m_ill = (m_ill == CNT_MAX) ? CNT_MAX : m_ill + 1;
            else        m_dec = (m_dec == CNT_MAX) ? CNT_MAX : m_dec + 1;
        end
        if (fl) sb_q.delete();
        else if (v && bus.in_ready) begin
            sb_q.push_back(ref_vec(ins, pc_ctr));
            pc_ctr = pc_ctr + 4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 0;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        tests++; if (observe() !== '0) begin fails++; $display("FAIL reset_outputs got=%0h exp=0", observe()); end
        tests++; if (bus.dec_count !== '0 || bus.ill_count !== '0) begin fails++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.dec_count, bus.ill_count); end
    endtask

    task automatic test_add();
        logic got; vec_t obs, exp;
        step(1, 32'h002081B3, 1, 0, got, obs, exp);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
        tests++; if ({bus.alu_control, bus.reg_write, bus.out_rd, bus.illegal} !== {6'd1, 1'b1, 5'd3, 1'b0}) begin fails++;
            $display("FAIL add_fields got alu=%0d rw=%0b rd=%0d ill=%0b exp 1/1/3/0", bus.alu_control, bus.reg_write, bus.out_rd, bus.illegal); end
        step(0, 0, 1, 0, got, obs, exp);
        tests++; if (!got || obs !== exp) begin fails++; $display("FAIL add_entry got=%0h exp=%0h", obs, exp); end
        tests++; if (bus.dec_count !== CW'(m_dec)) begin fails++; $display("FAIL add_dec_count got=%0d exp=%0d", bus.dec_count, m_dec); end
    endtask

    task automatic test_back_to_back();
        logic got; vec_t obs, exp; logic [31:0] ins[4]; int idx, n_out;
        foreach (ins[i]) ins[i] = gen_legal();
        idx = 0; n_out = 0;
        repeat (4) begin
            if (idx < 4 && bus.in_ready) begin step(1, ins[idx], 0, 0, got, obs, exp); idx++; end
            else step(1, ins[idx], 0, 0, got, obs, exp);
        end
        tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || idx != 2) begin fails++;
            $display("FAIL full_hold got in_ready=%0b out_valid=%0b accepted=%0d exp 0/1/2", bus.in_ready, bus.out_valid, idx); end
        for (int c = 0; c < 12; c++) begin
            if (idx < 4 && bus.in_ready) begin step(1, ins[idx], 1, 0, got, obs, exp); idx++; end
            else step(0, 0, 1, 0, got, obs, exp);
            if (got) begin
                n_out++;
                tests++; if (obs !== exp) begin fails++; $display("FAIL stream_entry got=%0h exp=%0h", obs, exp); end
            end
        end
        tests++; if (n_out != 4 || bus.out_valid !== 1'b0) begin fails++;
            $display("FAIL stream_count got=%0d valid=%0b exp=4/0", n_out, bus.out_valid); end
    endtask

    task automatic test_mem();
        logic got; vec_t obs, exp;
        step(1, 32'h0040C283, 0, 0, got, obs, exp);
        tests++; if ({bus.mem_read, bus.mem_to_reg, bus.mem_size, bus.mem_unsigned} !== 5'b11_00_1) begin fails++;
            $display("FAIL lbu_fields got=%0b%0b%0d%0b exp=1101", bus.mem_read, bus.mem_to_reg, bus.mem_size, bus.mem_unsigned); end
        step(1, 32'h0020A423, 1, 0, got, obs, exp);
        tests++; if (!got || obs !== exp) begin fails++; $display("FAIL lbu_entry got=%0h exp=%0h", obs, exp); end
        tests++; if ({bus.mem_write, bus.reg_write, bus.mem_to_reg} !== 3'b100) begin fails++;
            $display("FAIL sw_fields got mw=%0b rw=%0b m2r=%0b exp 1/0/0", bus.mem_write, bus.reg_write, bus.mem_to_reg); end
        step(0, 0, 1, 0, got, obs, exp);
        tests++; if (!got || obs !== exp) begin fails++; $display("FAIL sw_entry got=%0h exp=%0h", obs, exp); end
    endtask

    task automatic test_illegal();
        logic got; vec_t obs, exp; logic [31:0] bad[2];
        bad[0] = 32'h0000007F; bad[1] = 32'h023100B3;
        foreach (bad[i]) begin
            step(1, bad[i], 0, 0, got, obs, exp);
            tests++; if ({bus.illegal, bus.alu_control, bus.reg_write, bus.mem_read, bus.mem_write, bus.jump,
                          bus.branch_type, bus.lui_control} !== {1'b1, 14'b0}) begin fails++;
                $display("FAIL illegal_fields_%0d got=%0h", i, observe()); end
            step(0, 0, 1, 0, got, obs, exp);
            tests++; if (!got || obs !== exp) begin fails++; $display("FAIL illegal_entry_%0d got=%0h exp=%0h", i, obs, exp); end
            tests++; if (bus.ill_count !== CW'(m_ill)) begin fails++; $display("FAIL ill_count_%0d got=%0d exp=%0d", i, bus.ill_count, m_ill); end
        end
    endtask

    task automatic test_flush();
        logic got; vec_t obs, exp; int n_out; int dec_before;
        step(1, gen_legal(), 0, 0, got, obs, exp);
        step(1, gen_legal(), 0, 0, got, obs, exp);
        dec_before = m_dec;
        step(1, gen_legal(), 0, 1, got, obs, exp);
        flush = 0;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL flush_state got valid=%0b ready=%0b exp 0/1", bus.out_valid, bus.in_ready); end
        n_out = 0;
        repeat (3) begin step(0, 0, 1, 0, got, obs, exp); if (got) n_out++; end
        tests++; if (n_out != 0 || bus.dec_count !== CW'(dec_before)) begin fails++;
            $display("FAIL flush_drop got outs=%0d dec=%0d exp 0/%0d", n_out, bus.dec_count, dec_before); end
    endtask

    task automatic test_random();
        logic got; vec_t obs, exp; logic [31:0] w;
        for (int c = 0; c < 400; c++) begin
            tests++; if (bus.in_ready !== (sb_q.size() < 2) || bus.out_valid !== (sb_q.size() != 0)) begin fails++;
                $display("FAIL rand_occupancy c=%0d got ready=%0b valid=%0b entries=%0d", c, bus.in_ready, bus.out_valid, sb_q.size()); end
            w = ($urandom_range(0, 1) == 1) ? gen_legal() : $urandom;
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, got, obs, exp);
            if (got) begin
                tests++; if (obs !== exp) begin fails++; $display("FAIL rand_entry c=%0d got=%0h exp=%0h", c, obs, exp); end
            end
            tests++; if (bus.dec_count !== CW'(m_dec) || bus.ill_count !== CW'(m_ill)) begin fails++;
                $display("FAIL rand_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.dec_count, bus.ill_count, m_dec, m_ill); end
        end
        flush = 0;
    endtask

    task automatic test_saturate();
        logic got; vec_t obs, exp;
        repeat (CNT_MAX + 8) step(1, gen_legal(), 1, 0, got, obs, exp);
        repeat (3) step(0, 0, 1, 0, got, obs, exp);
        tests++; if (bus.dec_count !== CW'(CNT_MAX)) begin fails++;
            $display("FAIL dec_saturate got=%0d exp=%0d", bus.dec_count, CNT_MAX); end
        tests++; if (bus.ill_count !== CW'(m_ill)) begin fails++;
            $display("FAIL ill_after_saturate got=%0d exp=%0d", bus.ill_count, m_ill); end
    endtask

    initial begin
        build_table();
        test_reset();
        test_add();
        test_back_to_back();
        test_mem();
        test_illegal();
        test_flush();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
